// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register: a 2-entry elastic buffer (head + skid) with flush and NOP bubbles.
// Optional load-use stall on the input side when LOAD_USE_STALL_EN is defined.
module decode_execute_register #(
  parameter int WORD_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_branch,
  input  logic                     in_reg_write,
  input  logic                     in_mem_read,
  input  logic                     in_mem_to_reg,
  input  logic                     in_mem_write,
  input  logic                     in_alu_src,
  input  logic                     in_is_imm,
  input  logic [1:0]               in_alu_op,
  input  logic [WORD_SIZE-1:0]     in_pc,
  input  logic [WORD_SIZE-1:0]     in_rs1_data,
  input  logic [WORD_SIZE-1:0]     in_rs2_data,
  input  logic [WORD_SIZE-1:0]     in_imm,
  input  logic [REG_ADDR_SIZE-1:0] in_rs1,
  input  logic [REG_ADDR_SIZE-1:0] in_rs2,
  input  logic [REG_ADDR_SIZE-1:0] in_rd,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_branch,
  output logic                     out_reg_write,
  output logic                     out_mem_read,
  output logic                     out_mem_to_reg,
  output logic                     out_mem_write,
  output logic                     out_alu_src,
  output logic                     out_is_imm,
  output logic [1:0]               out_alu_op,
  output logic [WORD_SIZE-1:0]     out_pc,
  output logic [WORD_SIZE-1:0]     out_rs1_data,
  output logic [WORD_SIZE-1:0]     out_rs2_data,
  output logic [WORD_SIZE-1:0]     out_imm,
  output logic [REG_ADDR_SIZE-1:0] out_rs1,
  output logic [REG_ADDR_SIZE-1:0] out_rs2,
  output logic [REG_ADDR_SIZE-1:0] out_rd
);

  localparam int BW = 9 + 4 * WORD_SIZE + 3 * REG_ADDR_SIZE;

  logic [BW-1:0] w_in_bundle;
  logic [BW-1:0] w_out_bundle;
  logic [BW-1:0] r_head;
  logic [BW-1:0] r_skid;
  logic [1:0]    r_count;
  logic          w_push;
  logic          w_pop;
  logic          w_hazard;

  // All fields travel as one word so entries can never mix.
  assign w_in_bundle = {in_branch, in_reg_write, in_mem_read, in_mem_to_reg, in_mem_write,
                        in_alu_src, in_is_imm, in_alu_op, in_pc, in_rs1_data, in_rs2_data,
                        in_imm, in_rs1, in_rs2, in_rd};

  assign out_valid = (r_count != 2'd0);

  // Empty buffer presents an all-zero bundle, which is a NOP (alu_op=00, no writes).
  assign w_out_bundle = out_valid ? r_head : '0;

  assign {out_branch, out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write,
          out_alu_src, out_is_imm, out_alu_op, out_pc, out_rs1_data, out_rs2_data,
          out_imm, out_rs1, out_rs2, out_rd} = w_out_bundle;

`ifdef LOAD_USE_STALL_EN
  assign w_hazard = out_valid && out_mem_read && (out_rd != '0) && in_valid &&
                    ((in_rs1 == out_rd) || ((in_rs2 == out_rd) && !in_is_imm));
`else
  assign w_hazard = 1'b0;
`endif

  assign in_ready = !rst && (r_count != 2'd2) && !w_hazard;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_count <= 2'd0;
    end else begin
      case (r_count)
        2'd0:    if (w_push) r_count <= 2'd1;
        2'd1: begin
          if (w_push && !w_pop)      r_count <= 2'd2;
          else if (!w_push && w_pop) r_count <= 2'd0;
        end
        2'd2:    if (w_pop) r_count <= 2'd1;
        default: r_count <= 2'd0;
      endcase
    end
  end

  // Data registers carry no reset; validity is owned entirely by r_count.
  always_ff @(posedge clk) begin
    if (!flush) begin
      if ((r_count == 2'd0 && w_push) || (r_count == 2'd1 && w_push && w_pop)) begin
        r_head <= w_in_bundle;
      end else if (r_count == 2'd2 && w_pop) begin
        r_head <= r_skid;
      end
      if (r_count == 2'd1 && w_push && !w_pop) begin
        r_skid <= w_in_bundle;
      end
    end
  end

endmodule

// File: tb/tb_decode_execute_register.sv
// Self-checking bench for decode_execute_register: random and directed stimulus against a FIFO scoreboard model.
module tb_decode_execute_register;

  typedef struct packed {
    logic        branch;
    logic        reg_write;
    logic        mem_read;
    logic        mem_to_reg;
    logic        mem_write;
    logic        alu_src;
    logic        is_imm;
    logic [1:0]  alu_op;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } bundle_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic in_branch, in_reg_write, in_mem_read, in_mem_to_reg, in_mem_write, in_alu_src, in_is_imm;
  logic out_branch, out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src, out_is_imm;
  logic [1:0]  in_alu_op, out_alu_op;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [31:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd, out_rs1, out_rs2, out_rd;

  bundle_t in_b, out_b;
  bundle_t q[$];
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decode_execute_register #(.WORD_SIZE(32), .REG_ADDR_SIZE(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_branch(in_branch), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_to_reg(in_mem_to_reg), .in_mem_write(in_mem_write), .in_alu_src(in_alu_src),
    .in_is_imm(in_is_imm), .in_alu_op(in_alu_op), .in_pc(in_pc), .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_branch(out_branch), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_to_reg(out_mem_to_reg), .out_mem_write(out_mem_write), .out_alu_src(out_alu_src),
    .out_is_imm(out_is_imm), .out_alu_op(out_alu_op), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd)
  );

  assign in_b  = {in_branch, in_reg_write, in_mem_read, in_mem_to_reg, in_mem_write, in_alu_src,
                  in_is_imm, in_alu_op, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd};
  assign out_b = {out_branch, out_reg_write, out_mem_read, out_mem_to_reg, out_mem_write, out_alu_src,
                  out_is_imm, out_alu_op, out_pc, out_rs1_data, out_rs2_data, out_imm, out_rs1, out_rs2, out_rd};

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  task automatic chk_bun(input string name, input bundle_t act, input bundle_t exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Reference: an ordered queue of at most two accepted bundles.
  function automatic logic model_hazard();
    logic h;
    h = 1'b0;
`ifdef LOAD_USE_STALL_EN
    if (q.size() > 0 && q[0].mem_read && q[0].rd != 5'd0 && in_valid)
      h = (in_rs1 == q[0].rd) || (in_rs2 == q[0].rd && !in_is_imm);
`endif
    return h;
  endfunction

  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    exp_valid = (q.size() > 0);
    exp_ready = !rst && (q.size() < 2) && !model_hazard();
    chk_bit("out_valid", out_valid, exp_valid);
    chk_bit("in_ready", in_ready, exp_ready);
    if (exp_valid) chk_bun("head_bundle", out_b, q[0]);
    else           chk_bun("bubble_bundle", out_b, '0);
    if (rst || flush) begin
      q.delete();
    end else begin
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) q.push_back(in_b);
    end
  end

  function automatic bundle_t rand_bundle();
    bundle_t b;
    b = {$urandom, $urandom, $urandom, $urandom, $urandom};
    b.rs1 = 5'($urandom_range(0, 7));
    b.rs2 = 5'($urandom_range(0, 7));
    b.rd  = 5'($urandom_range(0, 7));
    return b;
  endfunction

  task automatic drive(input bundle_t b, input logic v);
    {in_branch, in_reg_write, in_mem_read, in_mem_to_reg, in_mem_write, in_alu_src,
     in_is_imm, in_alu_op, in_pc, in_rs1_data, in_rs2_data, in_imm, in_rs1, in_rs2, in_rd} = b;
    in_valid = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds in_valid until the DUT accepts the bundle, bounded.
  task automatic send_hold(input bundle_t b);
    int k;
    drive(b, 1'b1);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    n_chk++;
    if (k < 50) n_pass++;
    else $display("FAIL send_timeout at %0t: got no acceptance expected acceptance within 50 cycles", $time);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    bundle_t b;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive('0, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(1);

    // R-type push, drained immediately.
    out_ready = 1'b1;
    b = '0; b.reg_write = 1'b1; b.alu_op = 2'b10; b.rd = 5'd5; b.pc = 32'h100;
    drive(b, 1'b1); cyc(1); in_valid = 1'b0; cyc(3);

    // Three back-to-back pushes while execute is stalled, then drain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = rand_bundle(); b.pc = 32'(i * 4); b.mem_read = 1'b0;
      send_hold(b);
      if (i == 1) begin cyc(3); out_ready = 1'b1; end
    end
    cyc(4);

    // Steady stream: push and pop every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b = rand_bundle(); b.mem_read = 1'b0;
      drive(b, 1'b1); cyc(1);
    end
    in_valid = 1'b0; cyc(2);

    // Fill, then flush with a simultaneous push.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin b = rand_bundle(); b.mem_read = 1'b0; drive(b, 1'b1); cyc(1); end
    b = rand_bundle(); drive(b, 1'b1); flush = 1'b1; cyc(1);
    flush = 1'b0; in_valid = 1'b0; cyc(2);

    // Reset pulse while full.
    for (int i = 0; i < 2; i++) begin b = rand_bundle(); b.mem_read = 1'b0; drive(b, 1'b1); cyc(1); end
    in_valid = 1'b0; rst = 1'b1; cyc(1); rst = 1'b0; cyc(2);

    // Load at head, dependent and independent followers.
    b = '0; b.mem_read = 1'b1; b.mem_to_reg = 1'b1; b.reg_write = 1'b1; b.rd = 5'd7;
    drive(b, 1'b1); cyc(1);
    b = '0; b.rs1 = 5'd7; b.rs2 = 5'd1; drive(b, 1'b1); cyc(3);
    out_ready = 1'b1; cyc(2); out_ready = 1'b0; in_valid = 1'b0; cyc(1);
    b = '0; b.mem_read = 1'b1; b.rd = 5'd7; drive(b, 1'b1); cyc(1);
    b = '0; b.rs1 = 5'd0; b.rs2 = 5'd3; drive(b, 1'b1); cyc(2);
    b = '0; b.rs2 = 5'd7; b.is_imm = 1'b1; drive(b, 1'b1); cyc(2);
    out_ready = 1'b1; in_valid = 1'b0; cyc(4);

    // Random traffic including flushes and resets.
    for (int i = 0; i < 2000; i++) begin
      drive(rand_bundle(), 1'($urandom_range(0, 3) != 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      rst = ($urandom_range(0, 127) == 0);
      cyc(1);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(4);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
